// File: rtl/pc_if.sv
// pc_if: control inputs and fetch/status outputs of the program counter unit
interface pc_if;
    logic        imem_ready, zero_flag, branch_eq, branch_ne, jump, jump_reg, halt;
    logic [31:0] alu_out, imm;
    logic [25:0] jaddr;
    logic [31:0] pc, pc_plus4, retired;
    logic        imem_req, instr_valid, halted, misalign_err;
    modport slave (
        input  imem_ready, zero_flag, branch_eq, branch_ne, jump, jump_reg, halt, alu_out, imm, jaddr,
        output pc, pc_plus4, retired, imem_req, instr_valid, halted, misalign_err
    );
    modport master (
        output imem_ready, zero_flag, branch_eq, branch_ne, jump, jump_reg, halt, alu_out, imm, jaddr,
        input  pc, pc_plus4, retired, imem_req, instr_valid, halted, misalign_err
    );
endinterface

// File: rtl/pc_unit.sv
// pc_unit: fetch/exec program counter sequencer with branch, jump and halt control
module pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic clk,
    input logic rst_n,
    pc_if.slave bus
);
    typedef enum logic [1:0] {FETCH, EXEC, HALTED} state_t;
    state_t      r_state;
    logic [31:0] r_pc, r_retired;
    logic        r_misalign, r_imem_req, r_instr_valid, r_halted;
    logic [31:0] w_pc_plus4, w_next_pc;
    logic        w_taken;
    assign w_pc_plus4 = r_pc + 32'd4;
    assign w_taken    = (bus.branch_eq & bus.zero_flag) | (bus.branch_ne & ~bus.zero_flag);
    assign w_next_pc  = bus.jump_reg ? {bus.alu_out[31:2], 2'b00} :
                        bus.jump     ? {w_pc_plus4[31:28], bus.jaddr, 2'b00} :
                        w_taken      ? w_pc_plus4 + {bus.imm[29:0], 2'b00} : w_pc_plus4;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= FETCH;
            r_pc          <= RESET_PC;
            r_retired     <= '0;
            r_misalign    <= 1'b0;
            r_imem_req    <= 1'b1;
            r_instr_valid <= 1'b0;
            r_halted      <= 1'b0;
        end else begin
            case (r_state)
                FETCH: if (bus.imem_ready) begin
                    r_state       <= EXEC;
                    r_imem_req    <= 1'b0;
                    r_instr_valid <= 1'b1;
                end
                EXEC: begin
                    r_retired     <= r_retired + 32'd1;
                    r_instr_valid <= 1'b0;
                    if (bus.halt) begin
                        r_state  <= HALTED;
                        r_halted <= 1'b1;
                    end else begin
                        r_state    <= FETCH;
                        r_imem_req <= 1'b1;
                        r_pc       <= w_next_pc;
                        if (bus.jump_reg && bus.alu_out[1:0] != 2'b00) r_misalign <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
    assign bus.pc           = r_pc;
    assign bus.pc_plus4     = w_pc_plus4;
    assign bus.retired      = r_retired;
    assign bus.imem_req     = r_imem_req;
    assign bus.instr_valid  = r_instr_valid;
    assign bus.halted       = r_halted;
    assign bus.misalign_err = r_misalign;
endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed and randomized checks of pc_unit against an instruction-level model
module tb_pc_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    pc_if bus ();
    pc_unit #(.RESET_PC(32'h0000_0000)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    int n_chk = 0;
    int n_fail = 0;
    logic [31:0] m_pc, m_ret;
    logic        m_mis, m_halt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic garbage();
        bus.zero_flag = 1'($urandom);
        bus.branch_eq = 1'($urandom);
        bus.branch_ne = 1'($urandom);
        bus.jump      = 1'($urandom);
        bus.jump_reg  = 1'($urandom);
        bus.halt      = 1'($urandom);
        bus.alu_out   = $urandom;
        bus.imm       = $urandom;
        bus.jaddr     = 26'($urandom);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        garbage();
        bus.imem_ready = 1'($urandom);
        tick();
        rst_n = 1'b1;
        m_pc = 32'h0; m_ret = 32'h0; m_mis = 1'b0; m_halt = 1'b0;
        chk("rst_pc", bus.pc, 32'h0);
        chk("rst_retired", bus.retired, 32'h0);
        chk("rst_halted", bus.halted, 32'h0);
        chk("rst_misalign", bus.misalign_err, 32'h0);
        chk("rst_imem_req", bus.imem_req, 32'h1);
        chk("rst_instr_valid", bus.instr_valid, 32'h0);
    endtask

    function automatic logic [31:0] model_next(input logic [31:0] pc, input bit beq, bne, zf, j, jr,
                                               input logic [31:0] alu, im, input logic [25:0] ja);
        logic [31:0] pp4 = pc + 32'd4;
        if (jr) return alu - (alu % 4);
        if (j) return (pp4 & 32'hF000_0000) | ({6'd0, ja} * 4);
        if ((beq && zf) || (bne && !zf)) return pp4 + im * 4;
        return pp4;
    endfunction

    task automatic instr(input int stall, input bit beq, bne, zf, j, jr, h,
                         input logic [31:0] alu, im, input logic [25:0] ja);
        for (int i = 0; i < stall; i++) begin
            bus.imem_ready = 1'b0;
            garbage();
            tick();
            chk("stall_req", bus.imem_req, 32'h1);
            chk("stall_pc", bus.pc, m_pc);
            chk("stall_valid", bus.instr_valid, 32'h0);
        end
        bus.imem_ready = 1'b1;
        garbage();
        tick();
        chk("exec_valid", bus.instr_valid, 32'h1);
        chk("exec_req", bus.imem_req, 32'h0);
        chk("exec_pc", bus.pc, m_pc);
        chk("exec_pc_plus4", bus.pc_plus4, m_pc + 32'd4);
        bus.branch_eq = beq; bus.branch_ne = bne; bus.zero_flag = zf;
        bus.jump = j; bus.jump_reg = jr; bus.halt = h;
        bus.alu_out = alu; bus.imm = im; bus.jaddr = ja;
        bus.imem_ready = 1'($urandom);
        tick();
        m_ret = m_ret + 32'd1;
        if (h) m_halt = 1'b1;
        else begin
            m_pc = model_next(m_pc, beq, bne, zf, j, jr, alu, im, ja);
            if (jr && alu[1:0] != 2'b00) m_mis = 1'b1;
        end
        chk("post_pc", bus.pc, m_pc);
        chk("post_retired", bus.retired, m_ret);
        chk("post_halted", bus.halted, {31'd0, m_halt});
        chk("post_misalign", bus.misalign_err, {31'd0, m_mis});
        chk("post_req", bus.imem_req, {31'd0, !m_halt});
        chk("post_valid", bus.instr_valid, 32'h0);
    endtask

    initial begin
        garbage();
        bus.imem_ready = 1'b0;
        do_reset();
        for (int k = 0; k < 3; k++) instr(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("seq_pc", bus.pc, 32'h0000_000C);
        chk("seq_retired", bus.retired, 32'd3);
        instr(0, 0, 0, 0, 1, 0, 0, 0, 0, 26'h40);
        chk("jump_0x100", bus.pc, 32'h100);
        instr(0, 1, 0, 1, 0, 0, 0, 0, 32'hFFFF_FFFE, 0);
        chk("beq_taken", bus.pc, 32'h0FC);
        instr(0, 0, 0, 0, 1, 0, 0, 0, 0, 26'h40);
        instr(0, 1, 0, 0, 0, 0, 0, 0, 32'hFFFF_FFFE, 0);
        chk("beq_not_taken", bus.pc, 32'h104);
        instr(0, 0, 0, 0, 1, 0, 0, 0, 0, 26'h40);
        instr(0, 1, 1, 0, 0, 0, 0, 0, 32'hFFFF_FFFE, 0);
        chk("beq_bne_taken", bus.pc, 32'h0FC);
        instr(5, 0, 0, 0, 0, 1, 0, 32'h4000_0010, 0, 0);
        instr(0, 0, 0, 0, 1, 1, 0, 32'h0000_2002, 0, 26'h3FF_FFFF);
        chk("jr_priority", bus.pc, 32'h0000_2000);
        chk("jr_misalign", bus.misalign_err, 32'h1);
        instr(0, 0, 0, 0, 0, 1, 0, 32'h4000_0010, 0, 0);
        instr(0, 1, 1, 1, 1, 0, 0, 0, 32'h10, 26'h40);
        chk("jump_region", bus.pc, 32'h4000_0100);
        chk("misalign_sticky", bus.misalign_err, 32'h1);
        instr(1, 0, 0, 0, 0, 1, 0, 32'hFFFF_FFFC, 0, 0);
        instr(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("pc_wrap", bus.pc, 32'h0);
        force dut.r_retired = 32'hFFFF_FFFF;
        #1;
        release dut.r_retired;
        m_ret = 32'hFFFF_FFFF;
        instr(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("retired_wrap", bus.retired, 32'h0);
        for (int k = 0; k < 150; k++) begin
            logic [31:0] alu = $urandom;
            if ($urandom_range(0, 3) != 0) alu[1:0] = 2'b00;
            instr($urandom_range(0, 2), 1'($urandom), 1'($urandom), 1'($urandom),
                  $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0, 0, alu,
                  $urandom, 26'($urandom));
        end
        do_reset();
        instr(0, 0, 0, 0, 1, 0, 0, 0, 0, 26'h8);
        chk("pc_0x20", bus.pc, 32'h20);
        instr(0, 0, 0, 0, 1, 1, 1, 32'h1, 0, 26'h1234);
        for (int k = 0; k < 10; k++) begin
            garbage();
            bus.imem_ready = 1'($urandom);
            tick();
            chk("halt_pc", bus.pc, 32'h20);
            chk("halt_halted", bus.halted, 32'h1);
            chk("halt_req", bus.imem_req, 32'h0);
            chk("halt_valid", bus.instr_valid, 32'h0);
            chk("halt_retired", bus.retired, m_ret);
        end
        do_reset();
        instr(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        bus.imem_ready = 1'b1;
        tick();
        chk("mid_exec_valid", bus.instr_valid, 32'h1);
        do_reset();
        instr(2, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("after_reset_pc", bus.pc, 32'h4);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
